// File: rtl/seg7_scan_pkg.sv
// Shared constants and types for the 7-segment scan decoder:
// segment patterns (bit0..6 = a..g), FSM encoding and default parameters.
package seg7_scan_pkg;

    localparam int STABLE_N_DEF = 4;
    localparam int TIMEOUT_DEF  = 1024;

    localparam logic [6:0] PAT_BLANK = 7'h00;
    localparam logic [6:0] PAT_0     = 7'h3F;
    localparam logic [6:0] PAT_1     = 7'h06;
    localparam logic [6:0] PAT_2     = 7'h5B;
    localparam logic [6:0] PAT_3     = 7'h4F;
    localparam logic [6:0] PAT_4     = 7'h66;
    localparam logic [6:0] PAT_5     = 7'h6D;
    localparam logic [6:0] PAT_6     = 7'h7D;
    localparam logic [6:0] PAT_7     = 7'h07;
    localparam logic [6:0] PAT_8     = 7'h7F;
    localparam logic [6:0] PAT_9     = 7'h6F;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Strict 7-segment pattern decoder: only the exact glyphs 0..9 are valid,
// all-dark is reported as blank, everything else is invalid.
module seg7_pattern_decoder
    import seg7_scan_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       is_valid,
    output logic       is_blank
);

    // Pattern lookup.
    always_comb begin
        digit    = 4'd0;
        is_valid = 1'b1;
        is_blank = 1'b0;
        case (pattern)
            PAT_0:     digit = 4'd0;
            PAT_1:     digit = 4'd1;
            PAT_2:     digit = 4'd2;
            PAT_3:     digit = 4'd3;
            PAT_4:     digit = 4'd4;
            PAT_5:     digit = 4'd5;
            PAT_6:     digit = 4'd6;
            PAT_7:     digit = 4'd7;
            PAT_8:     digit = 4'd8;
            PAT_9:     digit = 4'd9;
            PAT_BLANK: begin
                is_valid = 1'b0;
                is_blank = 1'b1;
            end
            default:   is_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers a two-digit BCD value from a multiplexed 7-segment scan bus,
// committing only after STABLE_N identical valid frames and dropping lock on strobe silence.
module seg7_scan_decoder
    import seg7_scan_pkg::*;
#(
    parameter int STABLE_N = STABLE_N_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_in,
    input  logic [1:0] dig_in,
    input  logic       seg_pol,
    input  logic       dig_pol,
    input  logic       err_clr,
    output logic [3:0] digit1,
    output logic [3:0] digit10,
    output logic       valid,
    output logic       update,
    output logic       err
);

    localparam int CW = $clog2(STABLE_N + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_N);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] IDLE_ONE  = TW'(1);

    logic [6:0]    seg_s1_r, seg_s2_r, seg_n_s;
    logic [1:0]    dig_s1_r, dig_s2_r, dig_n_s, warm_r;
    logic          ones_s, tens_s, any_s, coll_s, ones_end_s, tens_end_s;
    logic          ones_prev_r, tens_prev_r, tens_seen_r, coll_seen_r;
    logic [5:0]    dec_s, ones_smp_r, tens_smp_r, tens_last_r, tens_cur_s;
    logic          tens_seen_s, tens_bad_s, frame_ok_s, frame_done_r, commit_s, timeout_s;
    logic [7:0]    frame_val_s, cand_r;
    logic [CW-1:0] cnt_r;
    logic [TW-1:0] idle_cnt_r;
    logic [3:0]    digit1_r, digit10_r;
    logic          valid_r, update_r, err_r, dp_unused_s;
    state_t        state_r, state_next_s;

    assign dp_unused_s = seg_in[7];

    // Two-flop synchronizers; warm_r masks strobes until the second stage holds pin data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1_r <= 7'd0;
            seg_s2_r <= 7'd0;
            dig_s1_r <= 2'd0;
            dig_s2_r <= 2'd0;
            warm_r   <= 2'd0;
        end else begin
            seg_s1_r <= seg_in[6:0];
            seg_s2_r <= seg_s1_r;
            dig_s1_r <= dig_in;
            dig_s2_r <= dig_s1_r;
            warm_r   <= (warm_r == 2'd2) ? warm_r : warm_r + 2'd1;
        end
    end

    assign seg_n_s    = seg_pol ? seg_s2_r : ~seg_s2_r;
    assign dig_n_s    = (warm_r == 2'd2) ? (dig_pol ? dig_s2_r : ~dig_s2_r) : 2'b00;
    assign ones_s     = dig_n_s[0];
    assign tens_s     = dig_n_s[1];
    assign any_s      = ones_s | tens_s;
    assign coll_s     = ones_s & tens_s;
    assign ones_end_s = ones_prev_r & ~ones_s;
    assign tens_end_s = tens_prev_r & ~tens_s;

    seg7_pattern_decoder u_dec (
        .pattern  (seg_n_s),
        .digit    (dec_s[3:0]),
        .is_valid (dec_s[5]),
        .is_blank (dec_s[4])
    );

    // A tens window closing in the same cycle as the ones window still belongs to this frame.
    assign tens_cur_s  = tens_end_s ? tens_smp_r : tens_last_r;
    assign tens_seen_s = tens_end_s | tens_seen_r;
    assign tens_bad_s  = tens_seen_s & ~tens_cur_s[5] & ~tens_cur_s[4];
    assign frame_ok_s  = ones_smp_r[5] & ~tens_bad_s & ~coll_seen_r;
    assign frame_val_s = {(tens_seen_s & tens_cur_s[5]) ? tens_cur_s[3:0] : 4'd0, ones_smp_r[3:0]};

    // Window sampling, tens hand-off and collision tracking between frame closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_prev_r <= 1'b0;
            tens_prev_r <= 1'b0;
            ones_smp_r  <= 6'd0;
            tens_smp_r  <= 6'd0;
            tens_last_r <= 6'd0;
            tens_seen_r <= 1'b0;
            coll_seen_r <= 1'b0;
        end else begin
            ones_prev_r <= ones_s;
            tens_prev_r <= tens_s;
            if (ones_s)     ones_smp_r  <= dec_s;
            if (tens_s)     tens_smp_r  <= dec_s;
            if (tens_end_s) tens_last_r <= tens_smp_r;
            if (timeout_s || ones_end_s) tens_seen_r <= 1'b0;
            else if (tens_end_s)         tens_seen_r <= 1'b1;
            if (ones_end_s)  coll_seen_r <= 1'b0;
            else if (coll_s) coll_seen_r <= 1'b1;
        end
    end

    // Stability counter over closed frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r        <= '0;
            cand_r       <= 8'd0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (timeout_s) begin
                cnt_r <= '0;
            end else if (ones_end_s) begin
                if (!frame_ok_s) begin
                    cnt_r <= '0;
                end else begin
                    frame_done_r <= 1'b1;
                    if (frame_val_s == cand_r) begin
                        if (cnt_r != CNT_MAX) cnt_r <= cnt_r + CNT_ONE;
                    end else begin
                        cand_r <= frame_val_s;
                        cnt_r  <= CNT_ONE;
                    end
                end
            end
        end
    end

    assign commit_s = frame_done_r & (cnt_r == CNT_MAX) &
                      (~valid_r | (cand_r != {digit10_r, digit1_r}));

    // Strobe-silence counter; only runs while acquiring or locked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_r <= '0;
        end else if (any_s || state_r == ST_IDLE || timeout_s) begin
            idle_cnt_r <= '0;
        end else begin
            idle_cnt_r <= idle_cnt_r + IDLE_ONE;
        end
    end

    assign timeout_s = (state_r != ST_IDLE) & ~any_s & (idle_cnt_r == IDLE_LAST);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_next_s;
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (commit_s)   state_next_s = ST_LOCKED;
                else if (any_s) state_next_s = ST_ACQUIRE;
                else            state_next_s = ST_IDLE;
            end
            ST_ACQUIRE: begin
                if (timeout_s)     state_next_s = ST_IDLE;
                else if (commit_s) state_next_s = ST_LOCKED;
                else               state_next_s = ST_ACQUIRE;
            end
            ST_LOCKED: begin
                if (timeout_s) state_next_s = ST_IDLE;
                else           state_next_s = ST_LOCKED;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Registered outputs; err setting wins over err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit1_r  <= 4'd0;
            digit10_r <= 4'd0;
            valid_r   <= 1'b0;
            update_r  <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            update_r <= commit_s;
            if (commit_s) begin
                digit10_r <= cand_r[7:4];
                digit1_r  <= cand_r[3:0];
                valid_r   <= 1'b1;
            end else if (timeout_s) begin
                valid_r <= 1'b0;
            end
            if (coll_s || (ones_end_s && !frame_ok_s)) err_r <= 1'b1;
            else if (err_clr)                          err_r <= 1'b0;
        end
    end

    assign digit1  = digit1_r;
    assign digit10 = digit10_r;
    assign valid   = valid_r;
    assign update  = update_r;
    assign err     = err_r;

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_N, default 4: consecutive identical valid frames required to commit a value.
REQ-002 SHALL have parameter TIMEOUT, default 1024: strobe-idle clk cycles before loss of lock.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port seg_in  input  8  multiplexed segment bus; bit0..6 = a..g, bit7 = dp (ignored).
REQ-006 SHALL have port dig_in  input  2  digit strobes; bit0 = ones, bit1 = tens.
REQ-007 SHALL have port seg_pol  input  1  1 = lit segment is high, 0 = lit segment is low (static).
REQ-008 SHALL have port dig_pol  input  1  1 = strobe active-high, 0 = active-low (static).
REQ-009 SHALL have port err_clr  input  1  clears err.
REQ-010 SHALL have ports digit1 / digit10  output  4 each  committed BCD ones / tens.
REQ-011 SHALL have port valid  output  1  a committed value is current (lock held).
REQ-012 SHALL have port update  output  1  one-cycle pulse on each commit.
REQ-013 SHALL have port err  output  1  sticky protocol error flag.

Function
REQ-014 SHALL pass seg_in[6:0] and dig_in through a 2-flop synchronizer, then normalize by seg_pol/dig_pol to active-high.
REQ-015 SHALL decode patterns strictly: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F (hex); 00 = blank; any other pattern invalid.
REQ-016 SHALL define a window as a contiguous run of an active normalized strobe; window sample = decoded pattern in its last active cycle.
REQ-017 SHALL close a frame at each ones-window end: tens = last tens-window sample if a tens window ended since the previous frame close, else 0; blank tens = 0.
REQ-018 SHALL mark a frame invalid if the ones sample is invalid or blank, the tens sample is invalid, or a collision occurred since the previous frame close.
REQ-019 SHALL treat both normalized strobes active in the same cycle as a collision: set err.
REQ-020 SHALL on invalid frame set err, reset stable count to 0, and not commit.
REQ-021 SHALL on valid frame: equal to candidate -> count+1 saturating at STABLE_N; else candidate = frame, count = 1.
REQ-022 SHALL commit when count reaches STABLE_N and (valid=0 or candidate differs from digit10/digit1): load digits, valid=1, update=1 for one cycle.
REQ-023 SHALL assert update exactly 3 clk cycles after the first edge sampling the deasserted ones strobe at the pins.
REQ-024 SHALL use FSM IDLE -> ACQUIRE (any strobe active) -> LOCKED (commit); LOCKED stays on mismatching/invalid frames with digits held.
REQ-025 SHALL count clk cycles with no strobe active, clearing on any active strobe; reaching TIMEOUT from ACQUIRE or LOCKED -> IDLE, valid=0, count=0, tens-seen cleared, digits held.
REQ-026 SHALL give err set priority over err_clr in the same cycle.
REQ-027 SHALL ignore strobe edges in the first 2 cycles after reset release (synchronizer warm-up).

Reset
REQ-028 SHALL on rst force digit1=0, digit10=0, valid=0, update=0, err=0, count=0, state IDLE, timeout counter 0, synchronizers 0.
REQ-029 SHALL on rst mid-window discard the partial window and candidate; no update afterward until STABLE_N fresh frames.

Structure
REQ-030 SHALL place segment pattern constants, FSM state encoding and default parameter values in shared package seg7_scan_pkg.
REQ-031 SHALL use one combinational sub-module seg7_pattern_decoder (7-bit pattern -> digit, is_valid, is_blank).

Verification
REQ-032 SHALL cover: pols=1, ones 4F, tens 06, 4 frames -> update 3 cycles after 4th ones end, digit10=1, digit1=3, valid=1.
REQ-033 SHALL cover: seg_pol=0, dig_pol=0, inverted patterns of REQ-032 -> identical result 13.
REQ-034 SHALL cover: tens never strobed, ones 7D, 4 frames -> digit10=0, digit1=6, valid=1.
REQ-035 SHALL cover: ones 49 in frame 3 of 4 -> err=1, no update; commit only after 4 further good frames.
REQ-036 SHALL cover: both strobes high 1 cycle -> err=1, that frame discarded; err_clr pulse -> err=0.
REQ-037 SHALL cover: locked at 13, 1024 idle cycles -> valid=0, digits 13, IDLE; rst after 2 good frames -> all outputs 0, no update.
